hazard_stall_ctrl: RTL and testbench

- Hazard/stall controller that sequences the Decode-stage pipeline register in the 5-stage MIPS pipeline.
- Compares D-stage source-operand Tuse against E/M-stage producer Tnew and generates the stall controls:
  - F_en freezes the PC.
  - D_en freezes the D register.
  - E_clr injects a bubble into the E register.
- Tracks a multi-cycle mult/div unit with a small FSM, so HI/LO consumers stall in D while it is busy.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard/stall controller for a 5-stage MIPS pipeline.
// Operand hazards compare the D-stage Tuse with the E- and M-stage Tnew. A
// small FSM tracks the mult/div unit so that HI/LO consumers wait in D. A
// saturating counter records how many cycles the pipeline has stalled.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        stat_clr,
  output logic        F_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam int unsigned STAT_W = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [1:0] TUSE_NONE = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_hz_md;
  logic w_md_busy;
  logic w_stall;

  // Hazard detection and stall outputs; reset forces the pipeline to run freely
  always_comb begin
    w_hz_rs = 1'b0;
    w_hz_rt = 1'b0;
    w_hz_rs = (D_rs != 5'd0) && (D_Tuse_rs != TUSE_NONE) &&
              (((D_rs == E_A3) && (D_Tuse_rs < E_Tnew)) ||
               ((D_rs == M_A3) && (D_Tuse_rs < M_Tnew)));
    w_hz_rt = (D_rt != 5'd0) && (D_Tuse_rt != TUSE_NONE) &&
              (((D_rt == E_A3) && (D_Tuse_rt < E_Tnew)) ||
               ((D_rt == M_A3) && (D_Tuse_rt < M_Tnew)));
    w_md_busy = reset && (md_start || (r_state == S_BUSY));
    w_hz_md   = D_md_use && w_md_busy;
    w_stall   = reset && (w_hz_rs || w_hz_rt || w_hz_md);
  end

  assign F_en      = ~w_stall;
  assign D_en      = ~w_stall;
  assign E_clr     = w_stall;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

  // Mult/div busy tracker: the countdown excludes the start cycle, and a restart while busy is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md_start) begin
            r_state <= S_BUSY;
            r_cnt   <= md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end
        end
        S_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; a clear takes priority over an increment on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != STAT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver pushes the expected outputs, and the monitor pops and compares them on each falling edge.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_md_use, md_start, md_is_div, stat_clr;
  logic        F_en, D_en, E_clr, md_busy;
  logic [31:0] stall_cnt;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_md_use(D_md_use), .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .md_start(md_start), .md_is_div(md_is_div), .stat_clr(stat_clr),
    .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f_en;
    logic        d_en;
    logic        e_clr;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   drv_done = 1'b0;

  // Reference model: the unit stays busy for a number of remaining cycles, and the counter saturates arithmetically
  int          md_rem = 0;
  longint      m_cnt  = 0;
  bit          m_stall = 1'b0;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  function automatic bit operand_waits(input logic [4:0] r, input logic [1:0] tuse);
    int unsigned ready_in[2];
    logic [4:0]  dst[2];
    bit w = 1'b0;
    dst[0] = E_A3; ready_in[0] = E_Tnew;
    dst[1] = M_A3; ready_in[1] = M_Tnew;
    if (r == 5'd0 || tuse == 2'd3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (dst[k] == r && int'(tuse) < int'(ready_in[k])) w = 1'b1;
    return w;
  endfunction

  task automatic model_eval();
    exp_t e;
    bit busy;
    if (!reset) begin
      md_rem  = 0;
      m_cnt   = 0;
      m_stall = 1'b0;
      e = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
    end else begin
      if (md_start && md_rem == 0) md_rem = md_is_div ? 10 : 5;
      busy    = (md_rem > 0);
      m_stall = operand_waits(D_rs, D_Tuse_rs) || operand_waits(D_rt, D_Tuse_rt) ||
                (D_md_use && busy);
      e = '{!m_stall, !m_stall, m_stall, busy, 32'(m_cnt)};
    end
    q.push_back(e);
  endtask

  task automatic model_edge();
    if (reset) begin
      if (stat_clr)                       m_cnt = 0;
      else if (m_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (md_rem > 0) md_rem = md_rem - 1;
    end
  endtask

  // Called at posedge+1 with the inputs already applied; returns at the next posedge+1
  task automatic step(input bit do_force);
    if (do_force) begin
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall_cnt;
      m_cnt = 64'h0000_0000_FFFF_FFFE;
    end
    model_eval();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1;
    D_rs = '0; D_rt = '0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_md_use = 1'b0;
    E_A3 = '0; E_Tnew = '0; M_A3 = '0; M_Tnew = '0;
    md_start = 1'b0; md_is_div = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: the outputs are stable at the falling edge, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("F_en",      32'(F_en),    32'(e.f_en));
        chk("D_en",      32'(D_en),    32'(e.d_en));
        chk("E_clr",     32'(E_clr),   32'(e.e_clr));
        chk("md_busy",   32'(md_busy), 32'(e.busy));
        chk("stall_cnt", stall_cnt,    e.cnt);
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs[4];
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd31;
    return regs[$urandom_range(0, 3)];
  endfunction

  // Driver: directed scenarios first, then randomized traffic
  initial begin
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    step(0); step(0);
    reset = 1'b1; step(0);

    // Load-use hazard, which resolves once the producer reaches M
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1; step(0);
    E_A3 = 5'd0; M_A3 = 5'd8; M_Tnew = 2'd1; step(0);
    idle_inputs();

    // $0, an unused operand, and Tuse equal to Tnew
    D_rs = 5'd0; E_A3 = 5'd0; E_Tnew = 2'd2; D_Tuse_rs = 2'd0; step(0);
    idle_inputs(); D_rt = 5'd9; E_A3 = 5'd9; E_Tnew = 2'd2; D_Tuse_rt = 2'd3; step(0);
    idle_inputs(); D_rs = 5'd9; E_A3 = 5'd9; E_Tnew = 2'd1; D_Tuse_rs = 2'd1; step(0);
    idle_inputs();

    // mult with a consumer waiting in D
    stat_clr = 1'b1; step(0); stat_clr = 1'b0;
    D_md_use = 1'b1; md_start = 1'b1; step(0);
    md_start = 1'b0;
    for (int i = 1; i < 7; i++) step(0);
    idle_inputs(); step(0);

    // div aborted by a reset pulse
    md_start = 1'b1; md_is_div = 1'b1; step(0);
    md_start = 1'b0; step(0); step(0);
    reset = 1'b0; step(0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(0);

    // Counter saturation, then a clear that overrides a concurrent stall
    E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd0;
    step(1); step(0); step(0); step(0);
    stat_clr = 1'b1; step(0); stat_clr = 1'b0;
    step(0);
    idle_inputs(); step(0);

    // A second md_start while busy is ignored
    md_start = 1'b1; step(0); md_start = 1'b0; step(0);
    md_start = 1'b1; step(0); md_start = 1'b0;
    for (int i = 3; i < 8; i++) step(0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      D_rs      = pick_reg(); D_rt = pick_reg();
      D_Tuse_rs = 2'($urandom_range(0, 3)); D_Tuse_rt = 2'($urandom_range(0, 3));
      E_A3      = pick_reg(); M_A3 = pick_reg();
      E_Tnew    = 2'($urandom_range(0, 3)); M_Tnew = 2'($urandom_range(0, 3));
      D_md_use  = 1'($urandom_range(0, 1));
      md_start  = ($urandom_range(0, 7) == 0);
      md_is_div = 1'($urandom_range(0, 1));
      stat_clr  = ($urandom_range(0, 49) == 0);
      step(0);
    end
    idle_inputs();
    drv_done = 1'b1;
  end

  // End of test: drain the scoreboard, then report
  initial begin
    wait (drv_done);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
